// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencer for an iterative DES round datapath plus C/D key schedule.
// Latency: job accepted at cycle 0, rounds 1..NUM_ROUNDS at cycles 1..NUM_ROUNDS
//          (advance_i held high), done_valid_o at cycle NUM_ROUNDS+1.
// Backpressure: advance_i stalls a round indefinitely; done_valid_o holds until
//          done_ready_i; ready_o is low while a job is in flight (no queuing).
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i / ready_o      job request handshake
//   decrypt_i, key_i       direction and C0||D0 (post-PC-1), sampled on accept
//   advance_i, abort_i     round commit request, synchronous job abort
//   load_o, round_en_o     datapath controls (load L0/R0, commit round)
//   round_idx_o, cd_o      current round number and C/D value for PC-2
//   last_round_o           current round is NUM_ROUNDS
//   done_valid_o/ready_i   result handshake
//
// Optional feature macro: DES_ROUND_CTRL_ZEROIZE_EN
//   defined   : C/D register cleared on DONE handshake and abort; cd_o is 0 outside ROUND.
//   undefined : C/D register keeps its value until the next accept; cd_o shows the register.
module des_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int ROUND_W    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               ready_o,
    input  logic               decrypt_i,
    input  logic [55:0]        key_i,
    input  logic               advance_i,
    input  logic               abort_i,
    output logic               load_o,
    output logic               round_en_o,
    output logic [ROUND_W-1:0] round_idx_o,
    output logic [55:0]        cd_o,
    output logic               last_round_o,
    output logic               done_valid_o,
    input  logic               done_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [55:0]        cd_q, cd_d;
    logic               dec_q, dec_d;

    // Rotate one 28-bit half left/right by 1 or 2, wrapping within the half.
    function automatic logic [27:0] rol28(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic dec,
                                           input logic two);
        if (dec)
            return {ror28(cd[55:28], two), ror28(cd[27:0], two)};
        else
            return {rol28(cd[55:28], two), rol28(cd[27:0], two)};
    endfunction

    // Rounds 1, 2, 9 and 16 use a single-bit shift; all others shift by two.
    // Indexed by the true round number so short builds follow the real schedule.
    function automatic logic one_shift(input int unsigned n);
        return (n == 1) || (n == 2) || (n == 9) || (n == 16);
    endfunction

    logic        is_last;
    int unsigned next_round;

    assign is_last    = (round_q == ROUND_W'(NUM_ROUNDS));
    assign next_round = 32'(round_q) + 32'd1;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        cd_d         = cd_q;
        dec_d        = dec_q;
        ready_o      = 1'b0;
        load_o       = 1'b0;
        round_en_o   = 1'b0;
        done_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort_i has no meaning here; an accept still happens.
                ready_o = 1'b1;
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = S_ROUND;
                    round_d = ROUND_W'(1);
                    dec_d   = decrypt_i;
                    // Decrypt starts from K16 = C0D0; encrypt pre-applies round-1 shift.
                    cd_d    = decrypt_i ? key_i : rot_cd(key_i, 1'b0, 1'b0);
                end
            end

            S_ROUND: begin
                if (abort_i) begin
                    // Abort wins over advance: the datapath must not commit this round.
                    state_d = S_IDLE;
                    round_d = '0;
`ifdef DES_ROUND_CTRL_ZEROIZE_EN
                    cd_d    = '0;
`endif
                end else if (advance_i) begin
                    round_en_o = 1'b1;
                    if (is_last) begin
                        state_d = S_DONE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        cd_d    = rot_cd(cd_q, dec_q, !one_shift(next_round));
                    end
                end
            end

            S_DONE: begin
                done_valid_o = 1'b1;
                if (abort_i || done_ready_i) begin
                    state_d = S_IDLE;
                    round_d = '0;
`ifdef DES_ROUND_CTRL_ZEROIZE_EN
                    cd_d    = '0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            cd_q    <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cd_q    <= cd_d;
            dec_q   <= dec_d;
        end
    end

    // The counter is held at 0 outside ROUND, so it can drive the index directly.
    assign round_idx_o  = round_q;
    assign last_round_o = (state_q == S_ROUND) && is_last;

`ifdef DES_ROUND_CTRL_ZEROIZE_EN
    assign cd_o = (state_q == S_ROUND) ? cd_q : '0;
`else
    assign cd_o = cd_q;
`endif

endmodule
